// File: rtl/modinv_pkg.sv
// Shared types and defaults for the modular-inverse scheduler.
// Optional engine watchdog is enabled by defining MODINV_TIMEOUT_EN.
package modinv_pkg;

    localparam int DEF_W    = 17;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/modinv_sched_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr.
// Produces a one-hot grant plus its binary index.
module rr_arbiter
    import modinv_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rr_ptr) + k) % NREQ;
            if (!any && req_valid[j[IW-1:0]]) begin
                any              = 1'b1;
                grant[j[IW-1:0]] = 1'b1;
                idx              = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/modinv_sched.sv
// Round-robin scheduler sharing one modular-inverse engine among requesters.
// Define MODINV_TIMEOUT_EN to add the engine watchdog (TIMEOUT cycles).
module modinv_sched
    import modinv_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = 4096,
    localparam int IW     = idx_w(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IW-1:0]   rsp_id,
    output logic [W-1:0]    rsp_data,
    output logic            rsp_err,
    output logic            eng_start,
    output logic [W-1:0]    eng_a,
    output logic [W-1:0]    eng_b,
    input  logic            eng_done,
    input  logic [W-1:0]    eng_result
);

    state_t          state, nxt;
    logic [IW-1:0]   rr_ptr;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;
    logic            gany;
    logic [W-1:0]    sel_a, sel_b;
    logic            hs, op_err, wd_hit;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .idx       (gidx),
        .any       (gany)
    );

    assign sel_a     = req_a[gidx*W +: W];
    assign sel_b     = req_b[gidx*W +: W];
    assign hs        = (state == IDLE) && gany;
    assign op_err    = (sel_a == '0) || (sel_b == '0);
    assign req_ready = (state == IDLE) ? grant : '0;
    assign eng_start = (state == ISSUE);
    assign rsp_valid = (state == RESP);

`ifdef MODINV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;

    // Counts completed WAIT cycles; fires on the TIMEOUT-th one.
    assign wd_hit = (state == WAIT) && !eng_done
                 && (wd_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wd_cnt <= '0;
        else if (state == ISSUE)
            wd_cnt <= '0;
        else if (state == WAIT)
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (hs) nxt = op_err ? RESP : ISSUE;
            ISSUE:   nxt = WAIT;
            WAIT:    if (eng_done || wd_hit) nxt = RESP;
            RESP:    if (rsp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            eng_a    <= '0;
            eng_b    <= '0;
        end else begin
            state <= nxt;
            if (hs) begin
                eng_a  <= sel_a;
                eng_b  <= sel_b;
                rsp_id <= gidx;
                rr_ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                if (op_err) begin
                    rsp_err  <= 1'b1;
                    rsp_data <= '0;
                end
            end
            if (state == WAIT) begin
                if (eng_done) begin
                    rsp_data <= eng_result;
                    rsp_err  <= 1'b0;
                end else if (wd_hit) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end
        end
    end

endmodule
